// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the data width, the NOP encoding, fetch FSM states and the FIFO entry layout.
package inst_fetch_unit_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  // addi x0,x0,0
  localparam data_t NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    data_t pc;
    data_t inst;
  } fetch_entry_t;

  // Word-align a fetch address by clearing bits [1:0].
  function automatic data_t align_pc(input data_t pc);
    return pc & ~DATA_W'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, inst} pairs with push, pop, flush and a head view.
// Pointers wrap naturally; count is one bit wider than the pointers.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage and pointer update; flush only rewinds pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC generation, single-outstanding I-cache handshake,
// redirect handling with stale-response drop, and a prefetch FIFO feeding IF_ID.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter data_t       RESET_PC = 32'h0000_0000,
  parameter data_t       NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        deqReady,
  output logic        cacheReq,
  output logic [31:0] cacheAddr,
  input  logic        cacheAck,
  input  logic [31:0] cacheData,
  output logic        instValid,
  output logic [31:0] pcOut,
  output logic [31:0] instOut
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_next;
  data_t            fetch_pc;
  data_t            fetch_pc_next;
  data_t            cache_addr_q;
  logic             cache_req_q;
  data_t            last_pc;

  logic             push;
  logic             pop;
  logic             flush;
  logic             space;
  logic             head_valid;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  fetch_entry_t     wdata;
  fetch_entry_t     head;

  assign head_valid = (count != '0);
  assign flush      = redirectValid;
  assign push       = (state == REQ) && cacheAck && !redirectValid;
  assign pop        = deqReady && head_valid && !redirectValid;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign space      = (count_next < CNT_W'(DEPTH));
  assign wdata      = '{pc: fetch_pc, inst: cacheData};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  // Fetch FSM next-state and PC selection.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    unique case (state)
      IDLE: begin
        if (redirectValid) begin
          fetch_pc_next = align_pc(redirectPc);
          state_next    = REQ;
        end else if (space) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirectValid) begin
          fetch_pc_next = align_pc(redirectPc);
          state_next    = cacheAck ? REQ : DROP;
        end else if (cacheAck) begin
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = space ? REQ : IDLE;
        end
      end
      DROP: begin
        // A redirect coinciding with the stale ack still retires the stale access.
        if (redirectValid) begin
          fetch_pc_next = align_pc(redirectPc);
          state_next    = cacheAck ? REQ : DROP;
        end else if (cacheAck) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and registered cache-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      cache_req_q  <= 1'b0;
      cache_addr_q <= RESET_PC;
      last_pc      <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      cache_req_q <= (state_next != IDLE);
      // DROP keeps presenting the stale address until its ack returns.
      if (state_next != DROP) begin
        cache_addr_q <= fetch_pc_next;
      end
      if (head_valid) begin
        last_pc <= head.pc;
      end
    end
  end

  assign cacheReq  = cache_req_q;
  assign cacheAddr = cache_addr_q;
  assign instValid = head_valid;
  assign pcOut     = head_valid ? head.pc   : last_pc;
  assign instOut   = head_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: cache responder, scoreboard of
// expected {pc, inst} pairs, and directed scenario tasks.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        deqReady;
  logic        cacheReq;
  logic [31:0] cacheAddr;
  logic        cacheAck;
  logic [31:0] cacheData;
  logic        instValid;
  logic [31:0] pcOut;
  logic [31:0] instOut;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit          auto_ack  = 0;
  bit          sb_on     = 0;
  int          ack_delay = 0;
  int          ack_cycles[$];
  logic [31:0] exp_pc_q[$];

  bit          pend      = 0;
  logic [31:0] pend_addr = '0;
  int          waited    = 0;

  inst_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .deqReady      (deqReady),
    .cacheReq      (cacheReq),
    .cacheAddr     (cacheAddr),
    .cacheAck      (cacheAck),
    .cacheData     (cacheData),
    .instValid     (instValid),
    .pcOut         (pcOut),
    .instOut       (instOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Cache model: acks after ack_delay waiting cycles, data = addr + 0x100.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!auto_ack || reset) begin
        pend   = 0;
        waited = 0;
        if (auto_ack) cacheAck = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (cacheReq !== 1'b1 || cacheAddr !== pend_addr) begin
            failures++;
            $display("FAIL req_stable got req=%b addr=%h exp req=1 addr=%h",
                     cacheReq, cacheAddr, pend_addr);
          end
        end
        if (cacheReq) begin
          if (waited == ack_delay) begin
            cacheAck  = 1'b1;
            cacheData = cacheAddr + 32'h100;
            waited    = 0;
            pend      = 0;
            ack_cycles.push_back(cyc);
          end else begin
            cacheAck  = 1'b0;
            waited++;
            pend      = 1;
            pend_addr = cacheAddr;
          end
        end else begin
          cacheAck = 1'b0;
          waited   = 0;
          pend     = 0;
        end
      end
    end
  end

  // Output monitor: NOP when empty, scoreboard on each pop, no push into full.
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dut.push) begin
          checks++;
          if (32'(dut.count) == DEPTH) begin
            failures++;
            $display("FAIL push_full got count=%0d exp below %0d", dut.count, DEPTH);
          end
        end
        if (!instValid) begin
          checks++;
          if (instOut !== NOP) begin
            failures++;
            $display("FAIL nop_out got=%h exp=%h", instOut, NOP);
          end
        end else if (sb_on && deqReady && !redirectValid) begin
          checks++;
          if (exp_pc_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra got pc=%h exp=no entry", pcOut);
          end else begin
            p = exp_pc_q.pop_front();
            if (pcOut !== p || instOut !== p + 32'h100) begin
              failures++;
              $display("FAIL sb_entry got pc=%h inst=%h exp pc=%h inst=%h",
                       pcOut, instOut, p, p + 32'h100);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    deqReady      = 1'b0;
    sb_on         = 0;
    exp_pc_q.delete();
    if (!auto_ack) cacheAck = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    auto_ack = 0;
    do_reset();
    reset    = 1'b1;
    deqReady = 1'b1;
    cacheAck = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b0 || cacheAddr !== 32'h0 || instValid !== 1'b0 ||
        pcOut !== 32'h0 || instOut !== NOP) begin
      failures++;
      $display("FAIL reset_vals got req=%b addr=%h v=%b pc=%h inst=%h exp 0/0/0/0/%h",
               cacheReq, cacheAddr, instValid, pcOut, instOut, NOP);
    end
    cacheAck = 1'b0;
  endtask

  task automatic test_zero_wait();
    auto_ack  = 1;
    ack_delay = 0;
    do_reset();
    deqReady = 1'b1;
    for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'(4 * i));
    sb_on = 1;
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b0) begin
      failures++;
      $display("FAIL zw_cycle0_req got=%b exp=0", cacheReq);
    end
    step();
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b1 || cacheAddr !== 32'h0 || instValid !== 1'b0) begin
      failures++;
      $display("FAIL zw_cycle1 got req=%b addr=%h v=%b exp 1/00000000/0",
               cacheReq, cacheAddr, instValid);
    end
    step();
    @(negedge clk);
    checks++;
    if (instValid !== 1'b1 || pcOut !== 32'h0 || cacheAddr !== 32'h4) begin
      failures++;
      $display("FAIL zw_cycle2 got v=%b pc=%h addr=%h exp 1/00000000/00000004",
               instValid, pcOut, cacheAddr);
    end
    for (int k = 3; k <= 8; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (cacheReq !== 1'b1 || cacheAddr !== 32'(4 * (k - 1))) begin
        failures++;
        $display("FAIL zw_addr got req=%b addr=%h exp 1/%h", cacheReq, cacheAddr, 32'(4 * (k - 1)));
      end
    end
    for (int i = 0; i < 40 && exp_pc_q.size() != 0; i++) step();
    checks++;
    if (exp_pc_q.size() != 0) begin
      failures++;
      $display("FAIL zw_drain got left=%0d exp=0", exp_pc_q.size());
    end
    sb_on    = 0;
    deqReady = 1'b0;
  endtask

  task automatic test_fill();
    int pushes = 0;
    auto_ack  = 1;
    ack_delay = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cacheReq && cacheAck) pushes++;
      step();
    end
    @(negedge clk);
    checks++;
    if (pushes != 4 || cacheReq !== 1'b0 || instValid !== 1'b1 ||
        pcOut !== 32'h0 || instOut !== 32'h100) begin
      failures++;
      $display("FAIL fill_full got pushes=%0d req=%b v=%b pc=%h inst=%h exp 4/0/1/00000000/00000100",
               pushes, cacheReq, instValid, pcOut, instOut);
    end
    exp_pc_q.push_back(32'h0);
    sb_on = 1;
    step();
    deqReady = 1'b1;
    step();
    deqReady = 1'b0;
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b1 || cacheAddr !== 32'h10 || pcOut !== 32'h4 ||
        instOut !== 32'h104 || exp_pc_q.size() != 0) begin
      failures++;
      $display("FAIL fill_pop got req=%b addr=%h pc=%h inst=%h left=%0d exp 1/00000010/00000004/00000104/0",
               cacheReq, cacheAddr, pcOut, instOut, exp_pc_q.size());
    end
    sb_on = 0;
  endtask

  task automatic test_wait_states();
    auto_ack  = 1;
    ack_delay = 3;
    do_reset();
    ack_cycles.delete();
    deqReady = 1'b1;
    for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'(4 * i));
    sb_on = 1;
    for (int i = 0; i < 60 && exp_pc_q.size() != 0; i++) step();
    checks++;
    if (exp_pc_q.size() != 0 || ack_cycles.size() < 4) begin
      failures++;
      $display("FAIL ws_drain got left=%0d acks=%0d exp 0/4", exp_pc_q.size(), ack_cycles.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ack_cycles[i+1] - ack_cycles[i] != 4) begin
          failures++;
          $display("FAIL ws_rate got gap=%0d exp=4", ack_cycles[i+1] - ack_cycles[i]);
        end
      end
    end
    sb_on     = 0;
    deqReady  = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_redirect_wait();
    auto_ack = 0;
    do_reset();
    step();
    cacheAck = 1'b1; cacheData = 32'h100;
    step();
    cacheAck = 1'b1; cacheData = 32'h104;
    step();
    cacheAck = 1'b0;
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b1 || cacheAddr !== 32'h8 || instValid !== 1'b1) begin
      failures++;
      $display("FAIL rw_wait got req=%b addr=%h v=%b exp 1/00000008/1", cacheReq, cacheAddr, instValid);
    end
    step();
    redirectValid = 1'b1; redirectPc = 32'h2002;
    step();
    redirectValid = 1'b0;
    cacheAck = 1'b1; cacheData = 32'h108;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheReq !== 1'b1 || cacheAddr !== 32'h8) begin
      failures++;
      $display("FAIL rw_drop got v=%b req=%b addr=%h exp 0/1/00000008", instValid, cacheReq, cacheAddr);
    end
    step();
    cacheAck = 1'b1; cacheData = 32'h2100;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheReq !== 1'b1 || cacheAddr !== 32'h2000) begin
      failures++;
      $display("FAIL rw_target got v=%b req=%b addr=%h exp 0/1/00002000", instValid, cacheReq, cacheAddr);
    end
    step();
    cacheAck = 1'b0;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b1 || pcOut !== 32'h2000 || instOut !== 32'h2100) begin
      failures++;
      $display("FAIL rw_head got v=%b pc=%h inst=%h exp 1/00002000/00002100", instValid, pcOut, instOut);
    end
  endtask

  task automatic test_redirect_drop();
    auto_ack = 0;
    do_reset();
    deqReady = 1'b1;
    step();
    cacheAck = 1'b1; cacheData = 32'h100;
    step();
    cacheAck = 1'b1; cacheData = 32'h104;
    redirectValid = 1'b1; redirectPc = 32'h3000;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b1 || pcOut !== 32'h0) begin
      failures++;
      $display("FAIL rd_pre got v=%b pc=%h exp 1/00000000", instValid, pcOut);
    end
    step();
    cacheAck = 1'b0; redirectPc = 32'h4001;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || pcOut !== 32'h0 || cacheReq !== 1'b1 || cacheAddr !== 32'h3000) begin
      failures++;
      $display("FAIL rd_first got v=%b pc=%h req=%b addr=%h exp 0/00000000/1/00003000",
               instValid, pcOut, cacheReq, cacheAddr);
    end
    step();
    redirectPc = 32'h5003;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheReq !== 1'b1 || cacheAddr !== 32'h3000) begin
      failures++;
      $display("FAIL rd_drop got v=%b req=%b addr=%h exp 0/1/00003000", instValid, cacheReq, cacheAddr);
    end
    step();
    redirectValid = 1'b0;
    cacheAck = 1'b1; cacheData = 32'h3100;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheAddr !== 32'h3000) begin
      failures++;
      $display("FAIL rd_drop2 got v=%b addr=%h exp 0/00003000", instValid, cacheAddr);
    end
    step();
    cacheAck = 1'b1; cacheData = 32'h5100;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheReq !== 1'b1 || cacheAddr !== 32'h5000) begin
      failures++;
      $display("FAIL rd_target got v=%b req=%b addr=%h exp 0/1/00005000", instValid, cacheReq, cacheAddr);
    end
    step();
    cacheAck = 1'b0;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b1 || pcOut !== 32'h5000 || instOut !== 32'h5100) begin
      failures++;
      $display("FAIL rd_head got v=%b pc=%h inst=%h exp 1/00005000/00005100", instValid, pcOut, instOut);
    end
    deqReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    auto_ack = 0;
    do_reset();
    step();
    cacheAck = 1'b1; cacheData = 32'h100;
    step();
    cacheAck = 1'b1; cacheData = 32'h104;
    step();
    cacheAck = 1'b0;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b1 || cacheReq !== 1'b1 || cacheAddr !== 32'h8) begin
      failures++;
      $display("FAIL rm_pre got v=%b req=%b addr=%h exp 1/1/00000008", instValid, cacheReq, cacheAddr);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cacheAck = 1'b1; cacheData = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b0 || cacheAddr !== 32'h0 || instValid !== 1'b0 ||
        pcOut !== 32'h0 || instOut !== NOP) begin
      failures++;
      $display("FAIL rm_reset got req=%b addr=%h v=%b pc=%h inst=%h exp 0/0/0/0/%h",
               cacheReq, cacheAddr, instValid, pcOut, instOut, NOP);
    end
    step();
    cacheAck = 1'b0;
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0 || cacheReq !== 1'b1 || cacheAddr !== 32'h0) begin
      failures++;
      $display("FAIL rm_after got v=%b req=%b addr=%h exp 0/1/00000000", instValid, cacheReq, cacheAddr);
    end
    step();
    @(negedge clk);
    checks++;
    if (instValid !== 1'b0) begin
      failures++;
      $display("FAIL rm_ignored got v=%b exp=0", instValid);
    end
  endtask

  task automatic test_wrap();
    auto_ack  = 1;
    ack_delay = 0;
    do_reset();
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFE;
    deqReady      = 1'b1;
    exp_pc_q.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) exp_pc_q.push_back(32'(4 * i));
    sb_on = 1;
    step();
    redirectValid = 1'b0;
    @(negedge clk);
    checks++;
    if (cacheReq !== 1'b1 || cacheAddr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_addr got req=%b addr=%h exp 1/fffffffc", cacheReq, cacheAddr);
    end
    for (int i = 0; i < 40 && exp_pc_q.size() != 0; i++) step();
    checks++;
    if (exp_pc_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain got left=%0d exp=0", exp_pc_q.size());
    end
    sb_on    = 0;
    deqReady = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    deqReady      = 1'b0;
    cacheAck      = 1'b0;
    cacheData     = '0;
    test_reset();
    test_zero_wait();
    test_fill();
    test_wait_states();
    test_redirect_wait();
    test_redirect_drop();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
